// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer: loadable mm:ss counter that decrements once per
// TICK_DIV clock cycles while running, with pause/resume, cancel and an
// alarm state once the count reaches 00:00. All outputs are registered.

module bcd_countdown_timer #(
    parameter int MIN_DIGITS = 2,
    parameter int TICK_DIV   = 4
) (
    input  logic                          clock,
    input  logic                          clrn,
    input  logic [4*(MIN_DIGITS+2)-1:0]   data,
    input  logic                          loadn,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          cancel,
    output logic [3:0]                    sec_ones,
    output logic [3:0]                    sec_tens,
    output logic [4*MIN_DIGITS-1:0]       mins,
    output logic                          zero,
    output logic                          running,
    output logic                          paused,
    output logic                          alarm,
    output logic                          done,
    output logic                          load_err
);

    localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  TICK_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Current state and datapath registers.
    state_t                  r_state;
    logic [3:0]              r_ones;
    logic [3:0]              r_tens;
    logic [4*MIN_DIGITS-1:0] r_mins;
    logic [PW-1:0]           r_presc;

    // Registered outputs.
    logic r_zero;
    logic r_running;
    logic r_paused;
    logic r_alarm;
    logic r_done;
    logic r_load_err;

    // Next-state values.
    state_t                  w_state_nxt;
    logic [3:0]              w_ones_nxt;
    logic [3:0]              w_tens_nxt;
    logic [4*MIN_DIGITS-1:0] w_mins_nxt;
    logic [PW-1:0]           w_presc_nxt;
    logic                    w_load_err_nxt;

    // Next output values.
    logic w_zero_nxt;
    logic w_running_nxt;
    logic w_paused_nxt;
    logic w_alarm_nxt;
    logic w_done_nxt;

    // Helper signals.
    logic [3:0]              w_dec_ones;
    logic [3:0]              w_dec_tens;
    logic [4*MIN_DIGITS-1:0] w_dec_mins;
    logic                    w_tick;
    logic                    w_last;
    logic                    w_cur_zero;
    logic                    w_load_ok;

    assign w_tick     = (r_state == S_RUN) && (r_presc == TICK_MAX);
    assign w_cur_zero = (r_mins == '0) && (r_tens == 4'd0) && (r_ones == 4'd0);
    assign w_last     = (r_mins == '0) && (r_tens == 4'd0) && (r_ones == 4'd1);

    // Check a load value: every digit BCD, seconds tens at most 5.
    always_comb begin
        w_load_ok = (data[3:0] <= 4'd9) && (data[7:4] <= 4'd5);
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (data[8+4*i +: 4] > 4'd9) begin
                w_load_ok = 1'b0;
            end
        end
    end

    // One-second decrement with BCD borrow chain ss -> minute digits.
    always_comb begin
        logic v_borrow;
        // NOTE: blocking assignments here because this is combinational; each
        // value is fully assigned first so no latch can be inferred.
        w_dec_ones = r_ones;
        w_dec_tens = r_tens;
        w_dec_mins = r_mins;
        v_borrow   = 1'b1;
        if (r_ones == 4'd0) begin
            w_dec_ones = 4'd9;
        end else begin
            w_dec_ones = r_ones - 4'd1;
            v_borrow   = 1'b0;
        end
        if (v_borrow) begin
            if (r_tens == 4'd0) begin
                w_dec_tens = 4'd5;
            end else begin
                w_dec_tens = r_tens - 4'd1;
                v_borrow   = 1'b0;
            end
        end
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (v_borrow) begin
                if (r_mins[4*i +: 4] == 4'd0) begin
                    w_dec_mins[4*i +: 4] = 4'd9;
                end else begin
                    w_dec_mins[4*i +: 4] = r_mins[4*i +: 4] - 4'd1;
                    v_borrow             = 1'b0;
                end
            end
        end
    end

    // Next-state and datapath: cancel > load > stop > start; ticks run underneath.
    always_comb begin
        w_state_nxt    = r_state;
        w_ones_nxt     = r_ones;
        w_tens_nxt     = r_tens;
        w_mins_nxt     = r_mins;
        w_presc_nxt    = r_presc;
        w_load_err_nxt = 1'b0;

        if (cancel) begin
            w_state_nxt = S_IDLE;
            w_ones_nxt  = 4'd0;
            w_tens_nxt  = 4'd0;
            w_mins_nxt  = '0;
            w_presc_nxt = '0;
        end else begin
            // Free-running countdown while in RUN; the 1 s -> 0 s tick raises the alarm.
            if (r_state == S_RUN) begin
                if (w_tick) begin
                    w_ones_nxt  = w_dec_ones;
                    w_tens_nxt  = w_dec_tens;
                    w_mins_nxt  = w_dec_mins;
                    w_presc_nxt = '0;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end

            if (!loadn) begin
                // A load request owns this cycle; it is silently ignored in RUN.
                if (r_state != S_RUN) begin
                    if (w_load_ok) begin
                        w_ones_nxt = data[3:0];
                        w_tens_nxt = data[7:4];
                        w_mins_nxt = data[4*(MIN_DIGITS+2)-1:8];
                        if (r_state == S_DONE) begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_load_err_nxt = 1'b1;
                    end
                end
            end else if (stop) begin
                if (r_state == S_RUN) begin
                    // Freeze the prescaler mid-second so resume keeps the phase.
                    if (!w_tick) begin
                        w_presc_nxt = r_presc;
                    end
                    if (!(w_tick && w_last)) begin
                        w_state_nxt = S_PAUSED;
                    end
                end
            end else if (start) begin
                if (r_state == S_IDLE && !w_cur_zero) begin
                    w_state_nxt = S_RUN;
                    w_presc_nxt = '0;
                end else if (r_state == S_PAUSED && !w_cur_zero) begin
                    w_state_nxt = S_RUN;
                end
            end
        end
    end

    // Output decode from the next state so every output comes from a flop.
    always_comb begin
        w_zero_nxt    = (w_mins_nxt == '0) && (w_tens_nxt == 4'd0) && (w_ones_nxt == 4'd0);
        w_running_nxt = (w_state_nxt == S_RUN);
        w_paused_nxt  = (w_state_nxt == S_PAUSED);
        w_alarm_nxt   = (w_state_nxt == S_DONE);
        w_done_nxt    = (w_state_nxt == S_DONE) && (r_state != S_DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge clrn) begin
        // NOTE: non-blocking assignments in clocked logic so every flop samples
        // the pre-edge values regardless of statement order.
        if (!clrn) begin
            r_state    <= S_IDLE;
            r_ones     <= 4'd0;
            r_tens     <= 4'd0;
            r_mins     <= '0;
            r_presc    <= '0;
            r_zero     <= 1'b1;
            r_running  <= 1'b0;
            r_paused   <= 1'b0;
            r_alarm    <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ones     <= w_ones_nxt;
            r_tens     <= w_tens_nxt;
            r_mins     <= w_mins_nxt;
            r_presc    <= w_presc_nxt;
            r_zero     <= w_zero_nxt;
            r_running  <= w_running_nxt;
            r_paused   <= w_paused_nxt;
            r_alarm    <= w_alarm_nxt;
            r_done     <= w_done_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    assign sec_ones = r_ones;
    assign sec_tens = r_tens;
    assign mins     = r_mins;
    assign zero     = r_zero;
    assign running  = r_running;
    assign paused   = r_paused;
    assign alarm    = r_alarm;
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed testbench for bcd_countdown_timer (MIN_DIGITS=2, TICK_DIV=4).
// Inputs change just after the falling edge; outputs are sampled on the
// falling edge, half a period away from the active rising edge.

module tb_bcd_countdown_timer;

    logic        clock;
    logic        clrn;
    logic [15:0] data;
    logic        loadn;
    logic        start;
    logic        stop;
    logic        cancel;
    logic [3:0]  sec_ones;
    logic [3:0]  sec_tens;
    logic [7:0]  mins;
    logic        zero;
    logic        running;
    logic        paused;
    logic        alarm;
    logic        done;
    logic        load_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Observed count as mm:ss BCD and status flags {zero,running,paused,alarm,done,load_err}.
    logic [15:0] cnt;
    logic [5:0]  flags;
    assign cnt   = {mins, sec_tens, sec_ones};
    assign flags = {zero, running, paused, alarm, done, load_err};

    bcd_countdown_timer #(
        .MIN_DIGITS (2),
        .TICK_DIV   (4)
    ) dut (
        .clock    (clock),
        .clrn     (clrn),
        .data     (data),
        .loadn    (loadn),
        .start    (start),
        .stop     (stop),
        .cancel   (cancel),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .mins     (mins),
        .zero     (zero),
        .running  (running),
        .paused   (paused),
        .alarm    (alarm),
        .done     (done),
        .load_err (load_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance n rising edges and land on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_load(input logic [15:0] v);
        data  = v;
        loadn = 1'b0;
        step(1);
        loadn = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        step(1);
        cancel = 1'b0;
    endtask

    task automatic test_reset();
        clrn = 1'b0; data = 16'h5555; loadn = 1'b1; start = 1'b0; stop = 1'b0; cancel = 1'b0;
        #12;
        n_tests++;
        if (cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt got=%h exp=%h", cnt, 16'h0000); end
        n_tests++;
        if (flags !== 6'b100000) begin n_fail++; $display("FAIL reset_flags got=%b exp=%b", flags, 6'b100000); end
        @(negedge clock);
        clrn = 1'b1;
        step(2);
        n_tests++;
        if (flags !== 6'b100000) begin n_fail++; $display("FAIL reset_release_flags got=%b exp=%b", flags, 6'b100000); end
    endtask

    task automatic test_countdown();
        do_load(16'h0003);
        n_tests++;
        if (cnt !== 16'h0003 || flags !== 6'b000000) begin n_fail++; $display("FAIL cd_load cnt=%h flags=%b exp 0003/000000", cnt, flags); end
        pulse_start();
        n_tests++;
        if (cnt !== 16'h0003 || flags !== 6'b010000) begin n_fail++; $display("FAIL cd_start cnt=%h flags=%b exp 0003/010000", cnt, flags); end
        step(3);
        n_tests++;
        if (cnt !== 16'h0003) begin n_fail++; $display("FAIL cd_before_tick got=%h exp=%h", cnt, 16'h0003); end
        step(1);
        n_tests++;
        if (cnt !== 16'h0002) begin n_fail++; $display("FAIL cd_tick1 got=%h exp=%h", cnt, 16'h0002); end
        step(4);
        n_tests++;
        if (cnt !== 16'h0001 || flags !== 6'b010000) begin n_fail++; $display("FAIL cd_tick2 cnt=%h flags=%b exp 0001/010000", cnt, flags); end
        step(3);
        n_tests++;
        if (flags !== 6'b010000) begin n_fail++; $display("FAIL cd_pre_done flags got=%b exp=%b", flags, 6'b010000); end
        step(1);
        n_tests++;
        if (cnt !== 16'h0000 || flags !== 6'b100110) begin n_fail++; $display("FAIL cd_done cnt=%h flags=%b exp 0000/100110", cnt, flags); end
        step(1);
        n_tests++;
        if (flags !== 6'b100100) begin n_fail++; $display("FAIL cd_done_pulse_width got=%b exp=%b", flags, 6'b100100); end
        pulse_start();
        stop = 1'b1; step(1); stop = 1'b0;
        n_tests++;
        if (cnt !== 16'h0000 || flags !== 6'b100100) begin n_fail++; $display("FAIL cd_done_ignore cnt=%h flags=%b exp 0000/100100", cnt, flags); end
        do_cancel();
        n_tests++;
        if (flags !== 6'b100000) begin n_fail++; $display("FAIL cd_cancel_done got=%b exp=%b", flags, 6'b100000); end
    endtask

    task automatic test_borrow();
        do_load(16'h0100);
        pulse_start();
        step(4);
        n_tests++;
        if (cnt !== 16'h0059) begin n_fail++; $display("FAIL borrow_min got=%h exp=%h", cnt, 16'h0059); end
        step(40);
        n_tests++;
        if (cnt !== 16'h0049) begin n_fail++; $display("FAIL borrow_tens got=%h exp=%h", cnt, 16'h0049); end
        do_cancel();
        do_load(16'h1000);
        pulse_start();
        step(4);
        n_tests++;
        if (cnt !== 16'h0959) begin n_fail++; $display("FAIL borrow_min_tens got=%h exp=%h", cnt, 16'h0959); end
        do_cancel();
        do_load(16'h9959);
        n_tests++;
        if (cnt !== 16'h9959 || load_err !== 1'b0) begin n_fail++; $display("FAIL max_load cnt=%h load_err=%b exp 9959/0", cnt, load_err); end
        do_cancel();
    endtask

    task automatic test_pause();
        do_load(16'h0005);
        pulse_start();
        step(4);
        step(2);
        stop = 1'b1; step(1); stop = 1'b0;
        n_tests++;
        if (cnt !== 16'h0004 || flags !== 6'b001000) begin n_fail++; $display("FAIL pause_enter cnt=%h flags=%b exp 0004/001000", cnt, flags); end
        step(20);
        n_tests++;
        if (cnt !== 16'h0004 || flags !== 6'b001000) begin n_fail++; $display("FAIL pause_hold cnt=%h flags=%b exp 0004/001000", cnt, flags); end
        pulse_start();
        n_tests++;
        if (cnt !== 16'h0004 || flags !== 6'b010000) begin n_fail++; $display("FAIL pause_resume cnt=%h flags=%b exp 0004/010000", cnt, flags); end
        step(1);
        n_tests++;
        if (cnt !== 16'h0004) begin n_fail++; $display("FAIL resume_early got=%h exp=%h", cnt, 16'h0004); end
        step(1);
        n_tests++;
        if (cnt !== 16'h0003) begin n_fail++; $display("FAIL resume_phase got=%h exp=%h", cnt, 16'h0003); end
        do_cancel();
        // Stop coinciding with the final tick: DONE wins over PAUSED.
        do_load(16'h0001);
        pulse_start();
        step(3);
        stop = 1'b1; step(1); stop = 1'b0;
        n_tests++;
        if (cnt !== 16'h0000 || flags !== 6'b100110) begin n_fail++; $display("FAIL stop_on_last_tick cnt=%h flags=%b exp 0000/100110", cnt, flags); end
        do_load(16'h0007);
        n_tests++;
        if (cnt !== 16'h0007 || flags !== 6'b000000) begin n_fail++; $display("FAIL load_from_done cnt=%h flags=%b exp 0007/000000", cnt, flags); end
        do_cancel();
    endtask

    task automatic test_load_err();
        do_load(16'h0012);
        do_load(16'h006A);
        n_tests++;
        if (cnt !== 16'h0012 || flags !== 6'b000001) begin n_fail++; $display("FAIL bad_ones cnt=%h flags=%b exp 0012/000001", cnt, flags); end
        step(1);
        n_tests++;
        if (load_err !== 1'b0) begin n_fail++; $display("FAIL load_err_width got=%b exp=%b", load_err, 1'b0); end
        do_load(16'h0070);
        n_tests++;
        if (cnt !== 16'h0012 || flags !== 6'b000001) begin n_fail++; $display("FAIL bad_tens cnt=%h flags=%b exp 0012/000001", cnt, flags); end
        do_load(16'hA000);
        n_tests++;
        if (cnt !== 16'h0012 || load_err !== 1'b1) begin n_fail++; $display("FAIL bad_mins cnt=%h load_err=%b exp 0012/1", cnt, load_err); end
        pulse_start();
        do_load(16'h0099);
        n_tests++;
        if (cnt !== 16'h0012 || flags !== 6'b010000) begin n_fail++; $display("FAIL load_in_run cnt=%h flags=%b exp 0012/010000", cnt, flags); end
        do_cancel();
    endtask

    task automatic test_cancel();
        do_load(16'h1234);
        pulse_start();
        step(2);
        cancel = 1'b1; loadn = 1'b0; data = 16'h0045;
        step(1);
        cancel = 1'b0; loadn = 1'b1;
        n_tests++;
        if (cnt !== 16'h0000 || flags !== 6'b100000) begin n_fail++; $display("FAIL cancel_over_load cnt=%h flags=%b exp 0000/100000", cnt, flags); end
        do_load(16'h1234);
        pulse_start();
        step(2);
        #2 clrn = 1'b0;
        #1;
        n_tests++;
        if (cnt !== 16'h0000 || flags !== 6'b100000) begin n_fail++; $display("FAIL async_clear cnt=%h flags=%b exp 0000/100000", cnt, flags); end
        @(negedge clock);
        clrn = 1'b1;
        step(6);
        n_tests++;
        if (cnt !== 16'h0000 || flags !== 6'b100000) begin n_fail++; $display("FAIL after_clear cnt=%h flags=%b exp 0000/100000", cnt, flags); end
        // Reset while in DONE drops the alarm at once.
        do_load(16'h0001);
        pulse_start();
        step(4);
        #2 clrn = 1'b0;
        #1;
        n_tests++;
        if (flags !== 6'b100000) begin n_fail++; $display("FAIL clear_in_done got=%b exp=%b", flags, 6'b100000); end
        @(negedge clock);
        clrn = 1'b1;
        step(1);
    endtask

    task automatic test_start_zero();
        pulse_start();
        n_tests++;
        if (flags !== 6'b100000) begin n_fail++; $display("FAIL start_zero got=%b exp=%b", flags, 6'b100000); end
        step(5);
        n_tests++;
        if (cnt !== 16'h0000 || running !== 1'b0) begin n_fail++; $display("FAIL start_zero_hold cnt=%h running=%b exp 0000/0", cnt, running); end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_pause();
        test_load_err();
        test_cancel();
        test_start_zero();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 Parameter MIN_DIGITS, default 2, number of BCD minute digits (legal 1..2).
REQ-002 Parameter TICK_DIV, default 4, clock cycles per one-second tick (legal >= 1).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 clrn  input  1  reset; asynchronous, active-low.
REQ-005 data  input  4*(MIN_DIGITS+2)  load value packed {mins, sec_tens, sec_ones}, sec_ones in [3:0].
REQ-006 loadn  input  1  synchronous load request, active-low.
REQ-007 start  input  1  start/resume request, active-high.
REQ-008 stop  input  1  pause request, active-high.
REQ-009 cancel  input  1  abort and clear request, active-high.
REQ-010 sec_ones  output  4  seconds units digit, BCD 0..9.
REQ-011 sec_tens  output  4  seconds tens digit, BCD 0..5.
REQ-012 mins  output  4*MIN_DIGITS  minute digits, BCD, least-significant digit in [3:0].
REQ-013 zero  output  1  high when all digits are 0.
REQ-014 running  output  1  high in state RUN.
REQ-015 paused  output  1  high in state PAUSED.
REQ-016 alarm  output  1  high in state DONE.
REQ-017 done  output  1  one-cycle pulse on entry to DONE.
REQ-018 load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-019 FSM states: IDLE, RUN, PAUSED, DONE; all outputs registered.
REQ-020 Request priority per cycle: cancel > loadn > stop > start.
REQ-021 Load valid iff every digit <= 9 and sec_tens <= 5; invalid load leaves digits and state unchanged and pulses load_err the next cycle.
REQ-022 Load accepted in IDLE, PAUSED and DONE; ignored (no load_err) in RUN; from DONE a valid load moves to IDLE, otherwise the state is kept.
REQ-023 cancel in any state: all digits to 0, prescaler to 0, state to IDLE on the next edge.
REQ-024 start in IDLE: if zero=0 then go to RUN with prescaler cleared to 0; if zero=1 it is ignored.
REQ-025 Prescaler counts 0..TICK_DIV-1 only in RUN; tick = RUN and prescaler == TICK_DIV-1; prescaler wraps to 0 on tick.
REQ-026 On a tick the count decrements by one second: sec_ones 0->9 with borrow; sec_tens 0->5 with borrow; minute digits 0->9 with borrow to the next minute digit.
REQ-027 Count never wraps below 00:00; a tick taking the count from 1 s to 0 moves to DONE on the same edge and done=1 for exactly that one cycle.
REQ-028 stop in RUN goes to PAUSED; prescaler value is held; a coincident tick still decrements (and may still enter DONE, which takes precedence over PAUSED).
REQ-029 start in PAUSED resumes RUN from the held prescaler value; ignored if zero=1.
REQ-030 start and stop in DONE are ignored; alarm stays high until cancel or a valid load.
REQ-031 start in RUN and stop in IDLE, PAUSED or DONE have no effect.
REQ-032 Maximum count 99:59 for MIN_DIGITS=2 and 9:59 for MIN_DIGITS=1.

Reset
REQ-033 clrn low immediately forces: state IDLE, all digits 0, prescaler 0, zero=1, running=paused=alarm=done=load_err=0.
REQ-034 Reset mid-RUN or mid-DONE aborts with no done pulse; after clrn rises the block stays in IDLE until a valid load followed by start.

Verification (TICK_DIV=4, MIN_DIGITS=2)
REQ-035 Load 00:03, start -> running=1; the count goes 2, 1, 0 at 4-cycle intervals; done pulses once at 00:00; alarm=1, running=0.
REQ-036 Load 01:00, start, wait 1 tick -> 00:59; after 10 more ticks -> 00:49 (checks the sec_tens and minute borrow).
REQ-037 Load 00:05, start, stop after 6 cycles -> paused=1 at 00:04, held for 20 cycles; start -> next decrement 2 cycles later (prescaler held at 2).
REQ-038 Load 00:6A (sec_ones=0xA), then load 00:70 -> both rejected with a load_err pulse each; digits keep their previous value.
REQ-039 In RUN at 12:34, assert cancel and loadn together -> IDLE, digits 00:00, load ignored; separately assert clrn low mid-RUN -> immediate 00:00 with no done pulse.
REQ-040 start with count 00:00 in IDLE -> state remains IDLE and running stays 0.
